// File: rtl/hazard_controller.sv
// ---------------------------------------------------------------------------
// hazard_controller
//   Pipeline sequencing controller for the 5-stage MIPS core. It sits beside
//   the ID-stage decoder and does four jobs:
//   - freezes PC and IF/ID and injects ID/EX bubbles for load-use hazards and
//     for JR-after-load hazards;
//   - flushes IF/ID on branches resolved taken in EX;
//   - runs a halt/drain handshake for the debug/test harness;
//   - keeps saturating stall and flush counters.
//
// Parameters
//   DRAIN_CYCLES : bubble cycles between halt entry and halt_ack (1..15)
//   CNT_W        : width of the stall/flush counters
//
// Ports
//   clk, reset                  : rising-edge clock, synchronous active-high reset
//   id_rs, id_rt                : source register fields of the ID instruction
//   id_uses_rs, id_uses_rt      : ID instruction actually reads rs / rt
//   id_jump                     : 00 none, 01 JR, 10 JR with forwarding, 11 JAL
//   ex_memread, ex_rd           : EX instruction is a load, and its destination
//   mem_memread, mem_rd         : MEM instruction is a load, and its destination
//   branch_taken                : branch resolved taken in EX this cycle
//   halt_req                    : level request to halt fetch and drain
//   pc_write, ifid_write        : PC / IF-ID load enables
//   ifid_flush, idex_bubble     : clear IF/ID, zero the ID/EX control bits
//   halt_ack                    : pipeline drained and halted
//   state                       : RUN=0, STALL=1, DRAIN=2, HALTED=3
//   stall_cycles, flush_cycles  : saturating performance counters
//
// The outputs are Mealy: they depend on the registered state and on the
// current inputs.
// ---------------------------------------------------------------------------
module hazard_controller #(
   parameter int DRAIN_CYCLES = 3,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rs,
   input  logic             id_uses_rt,
   input  logic [1:0]       id_jump,
   input  logic             ex_memread,
   input  logic [4:0]       ex_rd,
   input  logic             mem_memread,
   input  logic [4:0]       mem_rd,
   input  logic             branch_taken,
   input  logic             halt_req,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             ifid_flush,
   output logic             idex_bubble,
   output logic             halt_ack,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_cycles
);

   typedef enum logic [1:0] {
      S_RUN    = 2'd0,
      S_STALL  = 2'd1,
      S_DRAIN  = 2'd2,
      S_HALTED = 2'd3
   } state_t;

   localparam logic [3:0]       DRAIN_INIT = 4'(DRAIN_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

   state_t           r_state;
   state_t           w_next_state;
   logic [3:0]       r_drain_cnt;
   logic [3:0]       w_drain_next;
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;
   logic             w_stall_inc;
   logic             w_flush_inc;

   logic w_lu;
   logic w_jr;
   logic w_jr2;
   logic w_jr1;

   // Register index 0 is hard-wired zero, so it never creates a hazard.
   assign w_lu  = ex_memread && (ex_rd != 5'd0) &&
                  ((id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd)));
   assign w_jr  = (id_jump == 2'b01) || (id_jump == 2'b10);
   // A load in EX feeding JR needs two bubbles; a load in MEM needs one.
   // Non-load producers reach JR through the forwarding path.
   assign w_jr2 = w_jr && ex_memread && (ex_rd != 5'd0) && (ex_rd == id_rs);
   assign w_jr1 = w_jr && mem_memread && (mem_rd != 5'd0) && (mem_rd == id_rs);

   always_comb begin
      w_next_state = r_state;
      w_drain_next = r_drain_cnt;
      w_stall_inc  = 1'b0;
      w_flush_inc  = 1'b0;
      pc_write     = 1'b1;
      ifid_write   = 1'b1;
      ifid_flush   = 1'b0;
      idex_bubble  = 1'b0;
      halt_ack     = 1'b0;

      case (r_state)
         S_RUN: begin
            if (branch_taken) begin
               ifid_flush  = 1'b1;
               idex_bubble = 1'b1;
               w_flush_inc = 1'b1;
            end else if (w_jr2) begin
               pc_write     = 1'b0;
               ifid_write   = 1'b0;
               idex_bubble  = 1'b1;
               w_stall_inc  = 1'b1;
               w_next_state = S_STALL;
            end else if (w_lu || w_jr1) begin
               // Stay in RUN: the hazard is re-evaluated next cycle.
               pc_write    = 1'b0;
               ifid_write  = 1'b0;
               idex_bubble = 1'b1;
               w_stall_inc = 1'b1;
            end else if (halt_req) begin
               // The ID instruction advances; the IF instruction is dropped
               // and refetched from the frozen PC after the halt.
               pc_write     = 1'b0;
               ifid_flush   = 1'b1;
               w_drain_next = DRAIN_INIT;
               w_next_state = S_DRAIN;
            end
         end

         S_STALL: begin
            // Second bubble of a JR-after-load. A taken branch squashes the
            // stalled JR instead.
            w_next_state = S_RUN;
            if (branch_taken) begin
               ifid_flush  = 1'b1;
               idex_bubble = 1'b1;
               w_flush_inc = 1'b1;
            end else begin
               pc_write    = 1'b0;
               ifid_write  = 1'b0;
               idex_bubble = 1'b1;
               w_stall_inc = 1'b1;
            end
         end

         S_DRAIN: begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_bubble  = 1'b1;
            w_drain_next = r_drain_cnt - 4'd1;
            if (branch_taken) begin
               // Capture the branch target so the refetch after the halt
               // resumes on the correct path.
               pc_write    = 1'b1;
               ifid_flush  = 1'b1;
               w_flush_inc = 1'b1;
            end
            if (r_drain_cnt == 4'd1) begin
               w_next_state = S_HALTED;
            end
         end

         default: begin
            halt_ack    = 1'b1;
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            if (!halt_req) begin
               w_next_state = S_RUN;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_RUN;
         r_drain_cnt <= 4'd0;
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         r_state     <= w_next_state;
         r_drain_cnt <= w_drain_next;
         if (w_stall_inc && (r_stall_cnt != CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + CNT_ONE;
         end
         if (w_flush_inc && (r_flush_cnt != CNT_MAX)) begin
            r_flush_cnt <= r_flush_cnt + CNT_ONE;
         end
      end
   end

   assign state        = r_state;
   assign stall_cycles = r_stall_cnt;
   assign flush_cycles = r_flush_cnt;

endmodule

// File: tb/tb_hazard_controller.sv
// ---------------------------------------------------------------------------
// tb_hazard_controller
//   Self-checking bench for hazard_controller. It runs directed scenarios and
//   then randomized traffic. A cycle-level behavioural model tracks pending
//   bubbles, the drain countdown and the counters as plain integers. Two DUT
//   instances share the stimulus: one with CNT_W=16 and one with CNT_W=2, so
//   counter saturation is exercised.
// ---------------------------------------------------------------------------
module tb_hazard_controller;

   localparam int DRAIN = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  id_rs, id_rt, ex_rd, mem_rd;
   logic        id_uses_rs, id_uses_rt, ex_memread, mem_memread;
   logic [1:0]  id_jump;
   logic        branch_taken, halt_req;

   logic        pc_write, ifid_write, ifid_flush, idex_bubble, halt_ack;
   logic [1:0]  state;
   logic [15:0] stall_cycles, flush_cycles;

   logic        s_pc_write, s_ifid_write, s_ifid_flush, s_idex_bubble, s_halt_ack;
   logic [1:0]  s_state;
   logic [1:0]  s_stall_cycles, s_flush_cycles;

   int n_checks = 0;
   int n_errors = 0;

   // Behavioural model: plain integers rather than a state code.
   bit m_halted;
   int m_drain_left;   // bubble cycles still to run before halting
   bit m_extra_bubble; // second JR-after-load bubble still owed
   int m_stalls;
   int m_flushes;
   int cyc = 0;

   always #5 clk = ~clk;

   hazard_controller #(.DRAIN_CYCLES(DRAIN), .CNT_W(16)) u_dut (
      .clk(clk), .reset(reset),
      .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
      .id_jump(id_jump), .ex_memread(ex_memread), .ex_rd(ex_rd),
      .mem_memread(mem_memread), .mem_rd(mem_rd),
      .branch_taken(branch_taken), .halt_req(halt_req),
      .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
      .idex_bubble(idex_bubble), .halt_ack(halt_ack), .state(state),
      .stall_cycles(stall_cycles), .flush_cycles(flush_cycles)
   );

   hazard_controller #(.DRAIN_CYCLES(DRAIN), .CNT_W(2)) u_dut_small (
      .clk(clk), .reset(reset),
      .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
      .id_jump(id_jump), .ex_memread(ex_memread), .ex_rd(ex_rd),
      .mem_memread(mem_memread), .mem_rd(mem_rd),
      .branch_taken(branch_taken), .halt_req(halt_req),
      .pc_write(s_pc_write), .ifid_write(s_ifid_write), .ifid_flush(s_ifid_flush),
      .idex_bubble(s_idex_bubble), .halt_ack(s_halt_ack), .state(s_state),
      .stall_cycles(s_stall_cycles), .flush_cycles(s_flush_cycles)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   function automatic int sat(input int cnt, input int width);
      int max_val;
      max_val = (1 << width) - 1;
      return (cnt > max_val) ? max_val : cnt;
   endfunction

   task automatic model_reset();
      m_halted       = 1'b0;
      m_drain_left   = 0;
      m_extra_bubble = 1'b0;
      m_stalls       = 0;
      m_flushes      = 0;
   endtask

   task automatic idle();
      id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
      id_jump = 2'b00; ex_memread = 1'b0; ex_rd = 5'd0;
      mem_memread = 1'b0; mem_rd = 5'd0; branch_taken = 1'b0; halt_req = 1'b0;
   endtask

   // One clock cycle: inputs are already driven (just after a rising edge).
   // Compare outputs with the model, advance the model, move to the next edge.
   task automatic step();
      bit lu, jr, jr2, jr1;
      bit e_pc, e_ifw, e_fl, e_bub, e_ack;
      logic [1:0] e_st;
      #1;
      if (reset) begin
         model_reset();
         $display("cyc %0d reset", cyc);
      end else begin
         lu  = ex_memread && ex_rd != 0 &&
               ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
         jr  = (id_jump == 2'b01) || (id_jump == 2'b10);
         jr2 = jr && ex_memread && ex_rd != 0 && ex_rd == id_rs;
         jr1 = jr && mem_memread && mem_rd != 0 && mem_rd == id_rs;
         e_pc = 1; e_ifw = 1; e_fl = 0; e_bub = 0; e_ack = 0;

         // Counters are registered: compare before this cycle's increments.
         chk("stall_cycles", 32'(stall_cycles), 32'(sat(m_stalls, 16)));
         chk("flush_cycles", 32'(flush_cycles), 32'(sat(m_flushes, 16)));
         chk("stall_sat2", 32'(s_stall_cycles), 32'(sat(m_stalls, 2)));
         chk("flush_sat2", 32'(s_flush_cycles), 32'(sat(m_flushes, 2)));

         if (m_halted) begin
            e_st = 2'd3;
            e_ack = 1; e_pc = 0; e_ifw = 0; e_bub = 1;
            if (!halt_req) m_halted = 1'b0;
         end else if (m_drain_left > 0) begin
            e_st = 2'd2;
            e_pc = 0; e_ifw = 0; e_bub = 1;
            if (branch_taken) begin
               e_pc = 1; e_fl = 1; m_flushes++;
            end
            m_drain_left--;
            if (m_drain_left == 0) m_halted = 1'b1;
         end else if (m_extra_bubble) begin
            e_st = 2'd1;
            m_extra_bubble = 1'b0;
            if (branch_taken) begin
               e_fl = 1; e_bub = 1; m_flushes++;
            end else begin
               e_pc = 0; e_ifw = 0; e_bub = 1; m_stalls++;
            end
         end else begin
            e_st = 2'd0;
            if (branch_taken) begin
               e_fl = 1; e_bub = 1; m_flushes++;
            end else if (jr2 || lu || jr1) begin
               e_pc = 0; e_ifw = 0; e_bub = 1; m_stalls++;
               if (jr2) m_extra_bubble = 1'b1;
            end else if (halt_req) begin
               e_pc = 0; e_fl = 1;
               m_drain_left = DRAIN;
            end
         end

         chk("state", 32'(state), 32'(e_st));
         chk("outputs{pc,ifw,flush,bub,ack}",
             32'({pc_write, ifid_write, ifid_flush, idex_bubble, halt_ack}),
             32'({e_pc, e_ifw, e_fl, e_bub, e_ack}));
         chk("small_outputs",
             32'({s_state, s_pc_write, s_ifid_write, s_ifid_flush, s_idex_bubble, s_halt_ack}),
             32'({e_st, e_pc, e_ifw, e_fl, e_bub, e_ack}));
         $display("cyc %0d st=%0d pc=%0b ifw=%0b fl=%0b bub=%0b ack=%0b stalls=%0d flushes=%0d",
                  cyc, state, pc_write, ifid_write, ifid_flush, idex_bubble, halt_ack,
                  stall_cycles, flush_cycles);
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic apply_reset();
      idle();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   task automatic set_jr2();
      idle();
      id_jump = 2'b01; id_rs = 5'd31; id_uses_rs = 1'b1;
      ex_memread = 1'b1; ex_rd = 5'd31;
   endtask

   initial begin
      idle();
      reset = 1'b1;
      @(posedge clk);
      #1;
      apply_reset();

      // Reset values.
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_stall", 32'(stall_cycles), 32'd0);
      chk("rst_outs", 32'({pc_write, ifid_write, ifid_flush, idex_bubble, halt_ack}), 32'b11000);

      // Load-use: one bubble, then flow resumes.
      ex_memread = 1'b1; ex_rd = 5'd8; id_uses_rs = 1'b1; id_rs = 5'd8;
      step();
      idle();
      step();
      chk("lu_stall_cnt", 32'(stall_cycles), 32'd1);
      chk("lu_state", 32'(state), 32'd0);

      // JR after load: two bubbles through STALL.
      apply_reset();
      set_jr2();
      step();
      chk("jr2_state_stall", 32'(state), 32'd1);
      idle(); id_jump = 2'b01; id_rs = 5'd31; id_uses_rs = 1'b1;
      step();
      chk("jr2_state_run", 32'(state), 32'd0);
      chk("jr2_stall_cnt", 32'(stall_cycles), 32'd2);

      // Same case with ex_rd=0: no hazard.
      apply_reset();
      set_jr2(); ex_rd = 5'd0; id_rs = 5'd0;
      step();
      chk("jr_r0_state", 32'(state), 32'd0);
      chk("jr_r0_stall", 32'(stall_cycles), 32'd0);

      // Branch during the STALL cycle squashes the JR.
      apply_reset();
      set_jr2();
      step();
      idle(); branch_taken = 1'b1;
      step();
      chk("brstall_state", 32'(state), 32'd0);
      chk("brstall_flush", 32'(flush_cycles), 32'd1);
      chk("brstall_stall", 32'(stall_cycles), 32'd1);

      // Halt: entry, DRAIN x3, HALTED, release.
      apply_reset();
      halt_req = 1'b1;
      step();
      chk("halt_drain", 32'(state), 32'd2);
      for (int i = 0; i < DRAIN; i++) step();
      chk("halt_state", 32'(state), 32'd3);
      chk("halt_ack_hi", 32'(halt_ack), 32'd1);
      halt_req = 1'b0;
      step();
      chk("halt_release", 32'(state), 32'd0);
      chk("halt_ack_lo", 32'(halt_ack), 32'd0);

      // Branch in the 2nd DRAIN cycle does not change the drain length.
      apply_reset();
      halt_req = 1'b1;
      step();
      step();
      branch_taken = 1'b1;
      step();
      branch_taken = 1'b0;
      step();
      chk("drainbr_state", 32'(state), 32'd3);
      chk("drainbr_flush", 32'(flush_cycles), 32'd1);

      // Saturation: five load-use stalls.
      apply_reset();
      ex_memread = 1'b1; ex_rd = 5'd8; id_uses_rt = 1'b1; id_rt = 5'd8;
      for (int i = 0; i < 5; i++) step();
      idle();
      step();
      chk("sat_small", 32'(s_stall_cycles), 32'd3);
      chk("sat_big", 32'(stall_cycles), 32'd5);

      // Reset during DRAIN.
      apply_reset();
      halt_req = 1'b1;
      step();
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("rstdrain_state", 32'(state), 32'd0);
      chk("rstdrain_ack", 32'(halt_ack), 32'd0);
      chk("rstdrain_flush", 32'(flush_cycles), 32'd0);
      idle();
      step();

      // Randomized traffic; halt_req is a slowly toggling level.
      for (int i = 0; i < 1500; i++) begin
         id_rs        = 5'($urandom_range(0, 3));
         id_rt        = 5'($urandom_range(0, 3));
         id_uses_rs   = 1'($urandom_range(0, 1));
         id_uses_rt   = 1'($urandom_range(0, 1));
         id_jump      = 2'($urandom_range(0, 3));
         ex_memread   = 1'($urandom_range(0, 1));
         ex_rd        = 5'($urandom_range(0, 3));
         mem_memread  = 1'($urandom_range(0, 1));
         mem_rd       = 5'($urandom_range(0, 3));
         branch_taken = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 9) == 0) halt_req = ~halt_req;
         reset        = ($urandom_range(0, 199) == 0);
         step();
      end
      reset = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
